// File: rtl/collision_pkg.sv
// Shared helpers for the collision matrix: pair counting, pair indexing and
// width calculations used by both the controller and its event FIFO.
package collision_pkg;

  // Number of unordered object pairs for n objects.
  function automatic int num_pairs(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  // Flat index of pair (i,j), i<j, in row-major upper-triangle order.
  function automatic int pair_idx(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  // Ceiling log2 usable in parameter context.
  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // Width of a pair index; never narrower than one bit.
  function automatic int pair_w(input int n);
    int w;
    w = clog2_int(num_pairs(n));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/collision_matrix_ctrl_fifo.sv
// Small synchronous FIFO carrying hit-event pair indices to game logic.
// Head data reads as zero while empty so the consumer never sees stale data.
module hit_event_fifo
  import collision_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  localparam int AW = (clog2_int(DEPTH) < 1) ? 1 : clog2_int(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Status flags, head read-out and pointer/storage next-state.
  always_comb begin
    valid    = (wr_ptr_q != rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    data     = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    pop_ok   = pop & valid;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q + (push_ok ? 1'b1 : 1'b0);
    rd_ptr_d = rd_ptr_q + (pop_ok ? 1'b1 : 1'b0);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = push_data;
  end

  // Pointers reset asynchronously so a reset drops queued events at once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only observed through a valid head.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/collision_matrix_ctrl.sv
// Pairwise overlap detector for the VGA drawers: one hit pulse per pair per
// frame, a snapshot of the previous frame's hits, and a queue of hit events.
module collision_matrix_ctrl
  import collision_pkg::*;
#(
  parameter int                              NUM_OBJ    = 6,
  parameter logic [num_pairs(NUM_OBJ)-1:0]   PAIR_EN    = '1,
  parameter int                              FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              startOfFrame,
  input  logic [NUM_OBJ-1:0]                draw_req,
  output logic                              collision,
  output logic [num_pairs(NUM_OBJ)-1:0]     hit_pulse,
  output logic [num_pairs(NUM_OBJ)-1:0]     frame_hits,
  output logic                              event_valid,
  output logic [pair_w(NUM_OBJ)-1:0]        event_pair,
  input  logic                              event_ready,
  output logic                              overflow
);

  localparam int NUM_PAIRS = num_pairs(NUM_OBJ);
  localparam int PAIR_W    = pair_w(NUM_OBJ);

  logic [NUM_PAIRS-1:0] raw;
  logic [NUM_PAIRS-1:0] flag_eff;
  logic [NUM_PAIRS-1:0] new_hit;
  logic [NUM_PAIRS-1:0] dropped;
  logic [NUM_PAIRS-1:0] hit_flag_q,   hit_flag_d;
  logic [NUM_PAIRS-1:0] hit_pulse_q,  hit_pulse_d;
  logic [NUM_PAIRS-1:0] frame_hits_q, frame_hits_d;
  logic [NUM_PAIRS-1:0] pending_q,    pending_d;
  logic                 overflow_q,   overflow_d;
  logic [NUM_PAIRS-1:0] first_mask;
  logic [NUM_PAIRS-1:0] push_mask;
  logic [PAIR_W-1:0]    push_idx;
  logic                 found;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;

  // One overlap term per enabled object pair.
  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_row
    for (genvar gj = gi + 1; gj < NUM_OBJ; gj++) begin : g_col
      localparam int K = pair_idx(gi, gj, NUM_OBJ);
      assign raw[K] = draw_req[gi] & draw_req[gj] & PAIR_EN[K];
    end
  end

  assign collision = |raw;

  // Per-frame semaphore: a frame start forgets old flags but keeps hits
  // landing on that very cycle, which then belong to the new frame.
  always_comb begin
    flag_eff     = startOfFrame ? '0 : hit_flag_q;
    new_hit      = raw & ~flag_eff;
    hit_flag_d   = flag_eff | raw;
    hit_pulse_d  = new_hit;
    frame_hits_d = startOfFrame ? hit_flag_q : frame_hits_q;
  end

  // Lowest pending pair wins the single push slot; a simultaneous pop frees
  // room in a full FIFO.
  always_comb begin
    pop        = event_valid & event_ready;
    found      = 1'b0;
    push_idx   = '0;
    first_mask = '0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if (!found && pending_q[k]) begin
        found         = 1'b1;
        push_idx      = PAIR_W'(k);
        first_mask[k] = 1'b1;
      end
    end
    push      = found & (~fifo_full | pop);
    push_mask = push ? first_mask : '0;
  end

  // A new hit on a pair still waiting for the queue is lost and flagged.
  always_comb begin
    dropped    = new_hit & pending_q & ~push_mask;
    pending_d  = (pending_q & ~push_mask) | new_hit;
    overflow_d = overflow_q | (|dropped);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_flag_q   <= '0;
      hit_pulse_q  <= '0;
      frame_hits_q <= '0;
      pending_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      hit_flag_q   <= hit_flag_d;
      hit_pulse_q  <= hit_pulse_d;
      frame_hits_q <= frame_hits_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
    end
  end

  assign hit_pulse  = hit_pulse_q;
  assign frame_hits = frame_hits_q;
  assign overflow   = overflow_q;

  hit_event_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetN    (resetN),
    .push      (push),
    .push_data (push_idx),
    .full      (fifo_full),
    .pop       (pop),
    .valid     (event_valid),
    .data      (event_pair)
  );

endmodule

// File: tb/tb_collision_matrix_ctrl.sv
// Bench for collision_matrix_ctrl: three instances (default, pair 0 masked,
// two-entry FIFO) share stimulus and are tracked by a queue-level model.
module tb_collision_matrix_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        sof = 1'b0;
  logic [5:0]  req = '0;
  logic        ready = 1'b0;

  logic        coll_w  [3];
  logic [14:0] pulse_w [3];
  logic [14:0] fh_w    [3];
  logic        valid_w [3];
  logic [3:0]  epair_w [3];
  logic        ovf_w   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collision_matrix_ctrl #(.NUM_OBJ(6), .PAIR_EN(15'h7FFF), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_req(req),
    .collision(coll_w[0]), .hit_pulse(pulse_w[0]), .frame_hits(fh_w[0]),
    .event_valid(valid_w[0]), .event_pair(epair_w[0]), .event_ready(ready),
    .overflow(ovf_w[0]));

  collision_matrix_ctrl #(.NUM_OBJ(6), .PAIR_EN(15'h7FFE), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_req(req),
    .collision(coll_w[1]), .hit_pulse(pulse_w[1]), .frame_hits(fh_w[1]),
    .event_valid(valid_w[1]), .event_pair(epair_w[1]), .event_ready(ready),
    .overflow(ovf_w[1]));

  collision_matrix_ctrl #(.NUM_OBJ(6), .PAIR_EN(15'h7FFF), .FIFO_DEPTH(2)) dut_c (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_req(req),
    .collision(coll_w[2]), .hit_pulse(pulse_w[2]), .frame_hits(fh_w[2]),
    .event_valid(valid_w[2]), .event_pair(epair_w[2]), .event_ready(ready),
    .overflow(ovf_w[2]));

  // ---------------- reference model ----------------
  logic [14:0] m_flag [3];
  logic [14:0] m_fh   [3];
  logic [14:0] m_pend [3];
  logic [14:0] m_pulse[3];
  logic        m_ovf  [3];
  int          m_fifo [3][4];
  int          m_cnt  [3];

  function automatic logic [14:0] en_of(input int m);
    return (m == 1) ? 15'h7FFE : 15'h7FFF;
  endfunction

  function automatic int dep_of(input int m);
    return (m == 2) ? 2 : 4;
  endfunction

  // Pairs enumerated in order (0,1),(0,2)...(4,5) with a running counter.
  function automatic logic [14:0] model_raw(input logic [5:0] r, input logic [14:0] en);
    logic [14:0] res;
    int k;
    res = '0;
    k = 0;
    for (int i = 0; i < 6; i++)
      for (int j = i + 1; j < 6; j++) begin
        res[k] = r[i] & r[j] & en[k];
        k++;
      end
    return res;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_flag[m] = '0; m_fh[m] = '0; m_pend[m] = '0; m_pulse[m] = '0;
      m_ovf[m] = 1'b0; m_cnt[m] = 0;
      for (int s = 0; s < 4; s++) m_fifo[m][s] = 0;
    end
  endtask

  task automatic model_update();
    for (int m = 0; m < 3; m++) begin
      logic [14:0] raw, eff, newh, drop;
      logic        pop, can;
      int          pidx;
      raw  = model_raw(req, en_of(m));
      eff  = sof ? 15'h0 : m_flag[m];
      newh = raw & ~eff;
      pop  = (m_cnt[m] > 0) && ready;
      pidx = -1;
      for (int k = 14; k >= 0; k--) if (m_pend[m][k]) pidx = k;
      can  = (m_cnt[m] < dep_of(m)) || pop;
      if (pop) begin
        for (int s = 0; s < 3; s++) m_fifo[m][s] = m_fifo[m][s+1];
        m_cnt[m]--;
      end
      if (pidx >= 0 && can) begin
        m_fifo[m][m_cnt[m]] = pidx;
        m_cnt[m]++;
        m_pend[m][pidx] = 1'b0;
      end
      drop = newh & m_pend[m];
      if (drop != 0) m_ovf[m] = 1'b1;
      m_pend[m] = m_pend[m] | newh;
      if (sof) m_fh[m] = m_flag[m];
      m_flag[m]  = eff | raw;
      m_pulse[m] = newh;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Collision checked mid-cycle, registered outputs 1 time unit after the edge.
  task automatic step();
    @(negedge clk);
    for (int m = 0; m < 3; m++)
      chk($sformatf("collision[%0d]", m), 32'(coll_w[m]), 32'(|model_raw(req, en_of(m))));
    @(posedge clk);
    model_update();
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("hit_pulse[%0d]", m), 32'(pulse_w[m]), 32'(m_pulse[m]));
      chk($sformatf("frame_hits[%0d]", m), 32'(fh_w[m]), 32'(m_fh[m]));
      chk($sformatf("event_valid[%0d]", m), 32'(valid_w[m]), 32'(m_cnt[m] > 0));
      chk($sformatf("event_pair[%0d]", m), 32'(epair_w[m]),
          (m_cnt[m] > 0) ? 32'(m_fifo[m][0]) : 32'd0);
      chk($sformatf("overflow[%0d]", m), 32'(ovf_w[m]), 32'(m_ovf[m]));
    end
  endtask

  task automatic do_reset();
    req = '0; sof = 1'b0; ready = 1'b0;
    #2 resetN = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst_valid[%0d]", m), 32'(valid_w[m]), 32'd0);
      chk($sformatf("rst_pair[%0d]", m), 32'(epair_w[m]), 32'd0);
      chk($sformatf("rst_pulse[%0d]", m), 32'(pulse_w[m]), 32'd0);
      chk($sformatf("rst_fh[%0d]", m), 32'(fh_w[m]), 32'd0);
      chk($sformatf("rst_ovf[%0d]", m), 32'(ovf_w[m]), 32'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  typedef struct {
    logic [5:0]  req;
    logic        coll;
    logic [14:0] pulse;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int exp_q[3];

    tbl[0] = '{6'b000011, 1'b1, 15'h0001};
    tbl[1] = '{6'b110001, 1'b1, 15'h4018};
    tbl[2] = '{6'b000110, 1'b1, 15'h0020};
    tbl[3] = '{6'b100001, 1'b1, 15'h0010};
    tbl[4] = '{6'b110000, 1'b1, 15'h4000};
    tbl[5] = '{6'b000001, 1'b0, 15'h0000};
    tbl[6] = '{6'b000111, 1'b1, 15'h0023};
    tbl[7] = '{6'b111111, 1'b1, 15'h7FFF};

    do_reset();

    // Table: each vector on a frame start so every overlapping pair pulses.
    for (int v = 0; v < 8; v++) begin
      req = tbl[v].req; sof = 1'b1; ready = 1'b1;
      step();
      chk($sformatf("tbl%0d_coll", v), 32'(coll_w[0]), 32'(tbl[v].coll));
      chk($sformatf("tbl%0d_pulse", v), 32'(pulse_w[0]), 32'(tbl[v].pulse));
      chk($sformatf("tbl%0d_pulse_masked", v), 32'(pulse_w[1]), 32'(tbl[v].pulse & 15'h7FFE));
    end

    // Held overlap: a single pulse and a single event.
    do_reset();
    req = 6'b000011; cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) chk("hold_pulse_cycle1", 32'(pulse_w[0][0]), 32'd1);
      cnt += int'(pulse_w[0][0]);
      chk("hold_collision", 32'(coll_w[0]), 32'd1);
    end
    chk("hold_pulse_count", 32'(cnt), 32'd1);
    req = '0;
    step();
    chk("hold_event_valid", 32'(valid_w[0]), 32'd1);
    chk("hold_event_pair", 32'(epair_w[0]), 32'd0);
    ready = 1'b1;
    step();
    chk("hold_single_event", 32'(valid_w[0]), 32'd0);

    // Three simultaneous pairs drain in ascending order.
    do_reset();
    req = 6'b110001;
    step();
    chk("multi_pulse", 32'(pulse_w[0]), 32'h4018);
    chk("multi_valid_t1", 32'(valid_w[0]), 32'd0);
    req = '0;
    step();
    chk("multi_valid_t2", 32'(valid_w[0]), 32'd1);
    step();
    step();
    exp_q = '{3, 4, 14};
    ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("multi_order%0d", n), 32'(epair_w[0]), 32'(exp_q[n]));
      step();
    end
    chk("multi_empty", 32'(valid_w[0]), 32'd0);

    // Frame snapshot and re-arm of pair 5.
    do_reset();
    ready = 1'b1;
    req = 6'b000110;
    step();
    chk("p5_first_pulse", 32'(pulse_w[0][5]), 32'd1);
    req = '0;
    step();
    sof = 1'b1;
    step();
    sof = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("p5_frame_hits", 32'(fh_w[0][5]), 32'd1);
      step();
    end
    req = 6'b000110;
    step();
    chk("p5_second_pulse", 32'(pulse_w[0][5]), 32'd1);
    chk("p5_frame_hits_held", 32'(fh_w[0][5]), 32'd1);

    // Frame start coinciding with an already-flagged pair.
    do_reset();
    ready = 1'b1;
    req = 6'b001001;
    step();
    req = '0;
    step();
    req = 6'b001001; sof = 1'b1;
    step();
    chk("sof_pulse2", 32'(pulse_w[0][2]), 32'd1);
    chk("sof_fh2", 32'(fh_w[0][2]), 32'd1);
    req = '0; sof = 1'b0;
    step();
    sof = 1'b1;
    step();
    sof = 1'b0;
    chk("sof_counted_new_frame", 32'(fh_w[0][2]), 32'd1);

    // Disabled pair 0 on the masked instance.
    do_reset();
    req = 6'b000011;
    step();
    chk("masked_coll", 32'(coll_w[1]), 32'd0);
    chk("masked_pulse", 32'(pulse_w[1]), 32'd0);
    step();
    step();
    chk("masked_no_event", 32'(valid_w[1]), 32'd0);

    // Two-entry FIFO backs up across a frame; repeat hit overflows.
    do_reset();
    req = 6'b000011; step();
    req = 6'b000101; step();
    req = 6'b001001; step();
    req = '0; step(); step();
    chk("d2_valid", 32'(valid_w[2]), 32'd1);
    chk("d2_head", 32'(epair_w[2]), 32'd0);
    chk("d2_no_ovf_yet", 32'(ovf_w[2]), 32'd0);
    sof = 1'b1; step();
    sof = 1'b0; req = 6'b001001; step();
    req = '0; step();
    chk("d2_overflow", 32'(ovf_w[2]), 32'd1);
    chk("d4_no_overflow", 32'(ovf_w[0]), 32'd0);
    ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("d2_drain%0d", n), 32'(epair_w[2]), 32'(n));
      step();
    end
    chk("d2_empty", 32'(valid_w[2]), 32'd0);
    chk("d2_overflow_sticky", 32'(ovf_w[2]), 32'd1);

    // Randomized traffic against the model, with one mid-run reset.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if (c == 250) do_reset();
      req   = 6'($urandom) & 6'($urandom);
      sof   = ($urandom_range(0, 15) == 0);
      ready = (c < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_matrix_ctrl.md
# collision_matrix_ctrl

Parametrised collision controller for the VGA game pipeline. It sits between the per-object drawing-request outputs of the sprite/brick/border drawers and the game-logic blocks. It detects pixel overlap between any enabled pair of NUM_OBJ objects and issues at most one hit pulse per pair per frame. It also keeps a per-frame hit snapshot and queues hit events in a FIFO, which game logic drains with a valid/ready handshake.

## Interface
Parameters:
- NUM_OBJ, 6, number of drawing-request inputs (min 2, max 16)
- PAIR_EN, all ones, NUM_PAIRS-bit mask; bit k enables pair k
- FIFO_DEPTH, 4, hit-event FIFO depth (power of 2, min 2)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- draw_req  in  NUM_OBJ  drawing request per object, same pixel
- collision  out  1  combinational; any enabled pair overlapping this pixel
- hit_pulse  out  NUM_PAIRS  registered one-cycle pulse, first hit of pair k in a frame
- frame_hits  out  NUM_PAIRS  pairs hit during the previous frame
- event_valid  out  1  FIFO head valid
- event_pair  out  PAIR_W  pair index at FIFO head
- event_ready  in  1  consumer accepts head
- overflow  out  1  sticky; a hit event was dropped

## Operation
- Pair numbering: NUM_PAIRS = NUM_OBJ*(NUM_OBJ-1)/2, with PAIR_W = max(1, clog2(NUM_PAIRS)). Pair (i,j), i<j, has index k = i*NUM_OBJ - i*(i+1)/2 + (j-i-1). For NUM_OBJ=6: (0,1)=0, (0,5)=4, (1,2)=5, (4,5)=14.
- raw[k] = draw_req[i] & draw_req[j] & PAIR_EN[k]; collision = OR of raw.
- hit_flag[k] is the per-frame semaphore. On raw[k] with hit_flag[k]=0: assert hit_pulse[k] for the next cycle, set hit_flag[k], and set pending[k].
- Cycle with startOfFrame:
  - frame_hits <= hit_flag.
  - hit_flag cleared, except bits whose raw is set in this cycle. Those bits pulse and count in the new frame.
- Event queue:
  - Each cycle, the lowest-index set pending bit is pushed to the FIFO if the FIFO is not full, and that pending bit is cleared. One push per cycle.
  - Simultaneous multi-pair hits drain in ascending index order.
  - If raw[k] would set pending[k] while it is already set (FIFO backed up across frames), the new event is dropped and overflow is set. hit_pulse is still issued.
- FIFO pop happens when event_valid & event_ready. Push and pop in the same cycle are allowed when full.
- overflow clears only on reset.

## Timing
- Reset values: hit_pulse=0, frame_hits=0, event_valid=0, event_pair=0, overflow=0; hit_flag, pending and FIFO pointers cleared. collision follows its inputs.
- Latency:
  - raw at cycle t → hit_pulse at t+1, pending at t+1.
  - Earliest FIFO push at t+1; event_valid at t+2.
- event_pair is stable while event_valid=1 and event_ready=0.
- Reset mid-operation drops all queued events immediately.

## Structure
- Package collision_pkg holds:
  - function num_pairs(n)
  - function pair_idx(i,j,n)
  - constant-width helpers
- Sub-module: hit_event_fifo, a synchronous FIFO with params WIDTH and DEPTH and ports push/full/pop/valid/data. It is instantiated once.
- Pair generation uses generate loops over i<j. The priority encoder is a for-loop.

## Test plan
- NUM_OBJ=6. Hold draw_req=6'b000011 for 10 cycles within one frame → hit_pulse[0] high exactly one cycle, at cycle 1; one event with event_pair=0; collision high for all 10 cycles.
- draw_req=6'b110001 for one cycle, event_ready=0 → hit_pulse bits 3, 4 and 14 set together. FIFO then holds 3, 4, 14 in that order, and event_valid is first high 2 cycles after the hit.
- Hit pair 5 in frame N, then pulse startOfFrame → frame_hits[5]=1 for all of frame N+1. Hit pair 5 again in frame N+1 → pulses again.
- startOfFrame coincident with raw[2] while hit_flag[2]=1 → hit_pulse[2] asserts, and frame_hits[2]=1.
- PAIR_EN[0]=0 with draw_req=6'b000011 → collision=0, no pulse, no event.
- FIFO_DEPTH=2, event_ready=0, distinct hits on pairs 0, 1 and 2, then pair 2 again the next frame → pending[2] retained; the second hit sets overflow=1. Raise event_ready → events 0, 1, 2 drain in order.
